// File: rtl/life_pkg.sv
// Shared definitions for the life-like cell family: state codes, common
// 8-neighbour rule masks and the neighbour-count width helper.
package life_pkg;

    localparam int S_DEAD  = 0;
    localparam int S_ALIVE = 1;

    typedef struct packed {
        logic [8:0] birth;
        logic [8:0] survive;
    } rule8_t;

    // Bit k of a mask corresponds to k live neighbours.
    localparam rule8_t RULE_B3S23  = '{birth: 9'b0_0000_1000, survive: 9'b0_0000_1100};
    localparam rule8_t RULE_B36S23 = '{birth: 9'b0_0100_1000, survive: 9'b0_0000_1100};

    function automatic int count_width(input int n_neighbors);
        return $clog2(n_neighbors + 1);
    endfunction

endpackage

// File: rtl/life_cell_gen_popcount_n.sv
// Generic population count; the result width holds the full range 0..N.
module popcount_n #(
    parameter int N = 8
) (
    input  logic [N-1:0]           bits,
    output logic [$clog2(N+1)-1:0] count
);

    localparam int W = $clog2(N + 1);

    // Ripple sum of all input bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/life_cell_gen.sv
// Life-like cell with runtime birth/survive masks, Generations-style decay,
// a saturating age counter and registered birth/death pulses.
module life_cell_gen
    import life_pkg::*;
#(
    parameter int N_NEIGHBORS = 8,
    parameter int N_STATES    = 2,
    parameter int AGE_W       = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ena,
    input  logic                                 state_0,
    input  logic [N_NEIGHBORS:0]                 birth_mask,
    input  logic [N_NEIGHBORS:0]                 survive_mask,
    input  logic [N_NEIGHBORS-1:0]               neighbors,
    output logic [((N_STATES > 2) ? $clog2(N_STATES) : 1)-1:0] state_d,
    output logic [((N_STATES > 2) ? $clog2(N_STATES) : 1)-1:0] state_q,
    output logic                                 alive_q,
    output logic [AGE_W-1:0]                     age_q,
    output logic                                 born_q,
    output logic                                 died_q
);

    localparam int CW = count_width(N_NEIGHBORS);
    localparam int SW = (N_STATES > 2) ? $clog2(N_STATES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    logic [CW-1:0]    count_s;
    logic [AGE_W-1:0] age_next_s;
    logic             born_s;
    logic             died_s;

    popcount_n #(.N(N_NEIGHBORS)) u_popcount (
        .bits  (neighbors),
        .count (count_s)
    );

    // Next-state rule: masks only matter in the dead and alive states.
    always_comb begin
        state_d = SW'(S_DEAD);
        if (state_q == SW'(S_DEAD)) begin
            state_d = birth_mask[count_s] ? SW'(S_ALIVE) : SW'(S_DEAD);
        end else if (state_q == SW'(S_ALIVE)) begin
            if (survive_mask[count_s]) begin
                state_d = SW'(S_ALIVE);
            end else if (N_STATES == 2) begin
                state_d = SW'(S_DEAD);
            end else begin
                state_d = SW'(2);
            end
        end else if (int'(state_q) < N_STATES - 1) begin
            state_d = state_q + SW'(1);
        end else begin
            // Last dying state and unused encodings both fall back to dead.
            state_d = SW'(S_DEAD);
        end
    end

    // Age and event decode for the step being taken.
    always_comb begin
        born_s     = (state_q == SW'(S_DEAD))  && (state_d == SW'(S_ALIVE));
        died_s     = (state_q == SW'(S_ALIVE)) && (state_d != SW'(S_ALIVE));
        age_next_s = '0;
        if ((state_q == SW'(S_ALIVE)) && (state_d == SW'(S_ALIVE))) begin
            age_next_s = (age_q == AGE_MAX) ? AGE_MAX : age_q + AGE_W'(1);
        end else begin
            age_next_s = '0;
        end
    end

    // State, age and event registers; reset wins over ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SW'(state_0);
            alive_q <= state_0;
            age_q   <= '0;
            born_q  <= 1'b0;
            died_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            alive_q <= (state_d == SW'(S_ALIVE));
            age_q   <= age_next_s;
            born_q  <= born_s;
            died_q  <= died_s;
        end else begin
            born_q  <= 1'b0;
            died_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_life_cell_gen.sv
// Bench for life_cell_gen: Conway, Generations (4 states) and AGE_W=2 instances
// share stimulus; expected outputs are queued at drive time and popped after the edge.
module tb_life_cell_gen;
    import life_pkg::*;

    logic       clk = 1'b0;
    logic       rst, ena, state_0;
    logic [8:0] birth_mask, survive_mask;
    logic [7:0] neighbors;

    logic [0:0] c_state_d, c_state_q;
    logic       c_alive, c_born, c_died;
    logic [7:0] c_age;
    logic [1:0] g_state_d, g_state_q;
    logic       g_alive, g_born, g_died;
    logic [7:0] g_age;
    logic [0:0] a_state_d, a_state_q;
    logic       a_alive, a_born, a_died;
    logic [1:0] a_age;

    always #5 clk = ~clk;

    life_cell_gen #(.N_NEIGHBORS(8), .N_STATES(2), .AGE_W(8)) u_conway (
        .clk(clk), .rst(rst), .ena(ena), .state_0(state_0),
        .birth_mask(birth_mask), .survive_mask(survive_mask), .neighbors(neighbors),
        .state_d(c_state_d), .state_q(c_state_q), .alive_q(c_alive),
        .age_q(c_age), .born_q(c_born), .died_q(c_died));

    life_cell_gen #(.N_NEIGHBORS(8), .N_STATES(4), .AGE_W(8)) u_gen (
        .clk(clk), .rst(rst), .ena(ena), .state_0(state_0),
        .birth_mask(birth_mask), .survive_mask(survive_mask), .neighbors(neighbors),
        .state_d(g_state_d), .state_q(g_state_q), .alive_q(g_alive),
        .age_q(g_age), .born_q(g_born), .died_q(g_died));

    life_cell_gen #(.N_NEIGHBORS(8), .N_STATES(2), .AGE_W(2)) u_age (
        .clk(clk), .rst(rst), .ena(ena), .state_0(state_0),
        .birth_mask(birth_mask), .survive_mask(survive_mask), .neighbors(neighbors),
        .state_d(a_state_d), .state_q(a_state_q), .alive_q(a_alive),
        .age_q(a_age), .born_q(a_born), .died_q(a_died));

    typedef struct {
        int    dut;
        int    st;
        int    alive;
        int    age;
        int    born;
        int    died;
        string name;
    } exp_t;

    typedef struct {
        bit         s0;
        logic [8:0] bm;
        logic [8:0] sm;
        logic [7:0] nb;
        int         st;
        int         age;
        int         born;
        int         died;
        string      name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void cmp(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endfunction

    function automatic void push(int dut, int st, int age, int born, int died, string name);
        exp_t e;
        e.dut = dut; e.st = st; e.alive = (st == 1) ? 1 : 0;
        e.age = age; e.born = born; e.died = died; e.name = name;
        sb.push_back(e);
    endfunction

    task automatic check_out();
        exp_t e;
        int   st, al, ag, bo, di;
        e = sb.pop_front();
        case (e.dut)
            0: begin st = int'(c_state_q); al = int'(c_alive); ag = int'(c_age); bo = int'(c_born); di = int'(c_died); end
            1: begin st = int'(g_state_q); al = int'(g_alive); ag = int'(g_age); bo = int'(g_born); di = int'(g_died); end
            default: begin st = int'(a_state_q); al = int'(a_alive); ag = int'(a_age); bo = int'(a_born); di = int'(a_died); end
        endcase
        cmp({e.name, ".state_q"}, st, e.st);
        cmp({e.name, ".alive_q"}, al, e.alive);
        cmp({e.name, ".age_q"},   ag, e.age);
        cmp({e.name, ".born_q"},  bo, e.born);
        cmp({e.name, ".died_q"},  di, e.died);
    endtask

    task automatic tick_check();
        @(posedge clk);
        #1;
        while (sb.size() > 0) check_out();
    endtask

    task automatic do_reset(int dut, bit s0, string name);
        rst = 1'b1; ena = 1'b0; state_0 = s0;
        push(dut, int'(s0), 0, 0, 0, name);
        tick_check();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b0; state_0 = 1'b0;
        birth_mask = RULE_B3S23.birth; survive_mask = RULE_B3S23.survive; neighbors = 8'h00;

        vecs.push_back('{1'b0, RULE_B3S23.birth,  RULE_B3S23.survive,  8'b0000_0111, 1, 0, 1, 0, "b3_three"});
        vecs.push_back('{1'b1, RULE_B3S23.birth,  RULE_B3S23.survive,  8'b0000_0001, 0, 0, 0, 1, "s23_one"});
        vecs.push_back('{1'b1, RULE_B3S23.birth,  RULE_B3S23.survive,  8'b0001_0001, 1, 1, 0, 0, "s23_two"});
        vecs.push_back('{1'b1, RULE_B3S23.birth,  RULE_B3S23.survive,  8'b1010_0010, 1, 1, 0, 0, "s23_three"});
        vecs.push_back('{1'b1, RULE_B3S23.birth,  RULE_B3S23.survive,  8'b1111_0000, 0, 0, 0, 1, "s23_four"});
        vecs.push_back('{1'b0, RULE_B36S23.birth, RULE_B36S23.survive, 8'b0011_1111, 1, 0, 1, 0, "b36_six"});
        vecs.push_back('{1'b0, RULE_B3S23.birth,  RULE_B3S23.survive,  8'b0011_1111, 0, 0, 0, 0, "b3_six"});
        vecs.push_back('{1'b0, 9'b1_0000_0000,    RULE_B3S23.survive,  8'hFF,        1, 0, 1, 0, "b8_full"});
        vecs.push_back('{1'b1, RULE_B3S23.birth,  RULE_B3S23.survive,  8'hFF,        0, 0, 0, 1, "s23_full"});
        vecs.push_back('{1'b0, RULE_B3S23.birth,  RULE_B3S23.survive,  8'h00,        0, 0, 0, 0, "b3_none"});

        // Table: reset to the seed state, then one enabled step on the Conway cell.
        for (int i = 0; i < vecs.size(); i++) begin
            do_reset(0, vecs[i].s0, {vecs[i].name, ".rst"});
            birth_mask = vecs[i].bm; survive_mask = vecs[i].sm; neighbors = vecs[i].nb; ena = 1'b1;
            #1;
            cmp({vecs[i].name, ".state_d"}, int'(c_state_d), vecs[i].st);
            push(0, vecs[i].st, vecs[i].age, vecs[i].born, vecs[i].died, vecs[i].name);
            tick_check();
            ena = 1'b0;
        end

        // Generations decay 1->2->3->0 with neighbours ignored while dying.
        birth_mask = RULE_B3S23.birth; survive_mask = RULE_B3S23.survive;
        do_reset(1, 1'b1, "gen.rst");
        neighbors = 8'h00; ena = 1'b1;
        push(1, 2, 0, 0, 1, "gen.s2"); tick_check();
        neighbors = 8'hFF;
        #1; cmp("gen.state_d_s2", int'(g_state_d), 3);
        push(1, 3, 0, 0, 0, "gen.s3"); tick_check();
        push(1, 0, 0, 0, 0, "gen.s0"); tick_check();
        push(1, 0, 0, 0, 0, "gen.dead_full"); tick_check();

        // Reset with ena low while dying returns straight to the seed state.
        do_reset(1, 1'b1, "gen.rst2");
        neighbors = 8'h00; ena = 1'b1;
        push(1, 2, 0, 0, 1, "gen.decay"); tick_check();
        rst = 1'b1; ena = 1'b0; state_0 = 1'b1;
        push(1, 1, 0, 0, 0, "gen.rst_mid"); tick_check();
        rst = 1'b0;

        // Saturating age on the AGE_W=2 cell, then cleared by a death.
        do_reset(2, 1'b1, "age.rst");
        begin
            int age_m = 0;
            neighbors = 8'b0000_0011; ena = 1'b1;
            for (int k = 0; k < 6; k++) begin
                age_m = (age_m < 3) ? age_m + 1 : 3;
                push(2, 1, age_m, 0, 0, "age.sat"); tick_check();
            end
        end
        neighbors = 8'h00;
        push(2, 0, 0, 0, 1, "age.death"); tick_check();

        // ena low holds state/age and suppresses pulses.
        do_reset(0, 1'b0, "ena.rst");
        neighbors = 8'b0000_0111; ena = 1'b1;
        push(0, 1, 0, 1, 0, "ena.birth"); tick_check();
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            neighbors = 8'($urandom);
            push(0, 1, 0, 0, 0, "ena.hold"); tick_check();
        end
        neighbors = 8'b0001_0001; ena = 1'b1;
        push(0, 1, 1, 0, 0, "ena.step"); tick_check();
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            neighbors = 8'($urandom);
            push(0, 1, 1, 0, 0, "ena.hold2"); tick_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
